pulse_gen_multi: RTL and testbench

- Parametrised multi-channel successor to the single fixed-threshold periodic pulse counter.
- Each of CHANNELS independent channels counts clk cycles against its own programmable terminal value and emits a one-cycle pulse.
- Per-channel periodic or one-shot mode; register-style config port; per-channel run gating.
- Used as a tick/timebase source for test benches and small SoC peripherals.

---
 rtl/pulse_gen_pkg.sv | 15 +
 rtl/pulse_gen_chan.sv | 65 ++++++
 rtl/pulse_gen_multi.sv | 68 ++++++
 tb/tb_pulse_gen_multi.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel pulse generator.
//   mode_e    : per-channel mode, periodic or one-shot
//   ch_idx_w  : width of a channel index, never less than one bit
package pulse_gen_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  function automatic int ch_idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_gen_chan.sv
// One pulse generator channel: counts enabled clk cycles up to its terminal
// value, emits a one-cycle registered pulse and restarts (periodic) or stops
// with done set (one-shot).
//   clk, rst_n : clock, async active-low reset
//   run        : count enable, level-sensitive
//   clr        : sync clear of cnt/out/done (term and mode kept)
//   wr         : load term_in/mode_in and restart the channel
//   out        : one-cycle pulse
//   done       : sticky one-shot completion flag
//   cnt        : current counter value
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int RST_TERM = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] term_in,
  input  mode_e            mode_in,
  output logic             out,
  output logic             done,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] TERM_RST = WIDTH'(RST_TERM);

  logic [WIDTH-1:0] term;
  mode_e            mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      out  <= 1'b0;
      done <= 1'b0;
      term <= TERM_RST;
      mode <= MODE_PERIODIC;
    end else if (clr) begin
      cnt  <= '0;
      out  <= 1'b0;
      done <= 1'b0;
    end else if (wr) begin
      // A write wins over a coincident terminal hit: no pulse this cycle.
      term <= term_in;
      mode <= mode_in;
      cnt  <= '0;
      out  <= 1'b0;
      done <= 1'b0;
    end else if (!run || done) begin
      out <= 1'b0;
    end else if (cnt >= term) begin
      // ">=" also catches a term lowered below the running count.
      out <= 1'b1;
      cnt <= '0;
      if (mode == MODE_ONESHOT) done <= 1'b1;
    end else begin
      out <= 1'b0;
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel periodic / one-shot pulse generator.
//   clk, rst_n : clock, async active-low reset
//   run        : per-channel count enable
//   clr        : sync clear of all counters, pulses and done flags
//   cfg_wr     : config write strobe; cfg_ch selects the channel,
//                cfg_term/cfg_mode are the values written
//   out        : per-channel one-cycle pulse
//   done       : per-channel one-shot completed flag
//   cnt_mon    : registered counter value of channel cfg_ch (0 if out of range)
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int RST_TERM = 21
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CHANNELS-1:0]               run,
  input  logic                              clr,
  input  logic                              cfg_wr,
  input  logic [ch_idx_w(CHANNELS)-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]                  cfg_term,
  input  logic                              cfg_mode,
  output logic [CHANNELS-1:0]               out,
  output logic [CHANNELS-1:0]               done,
  output logic [WIDTH-1:0]                  cnt_mon
);

  logic [WIDTH-1:0] cnt_arr [CHANNELS];
  logic [WIDTH-1:0] mon_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr_ch;

    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    assign wr_ch = cfg_wr && (int'(cfg_ch) == i);

    pulse_gen_chan #(
      .WIDTH    (WIDTH),
      .RST_TERM (RST_TERM)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run[i]),
      .clr     (clr),
      .wr      (wr_ch),
      .term_in (cfg_term),
      .mode_in (mode_e'(cfg_mode)),
      .out     (out[i]),
      .done    (done[i]),
      .cnt     (cnt_arr[i])
    );
  end

  always_comb begin
    mon_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(cfg_ch) == i) mon_nxt = cnt_arr[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_mon <= '0;
    else        cnt_mon <= mon_nxt;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;

  logic        clk;
  logic        rst_n;
  logic [3:0]  run;
  logic        clr;
  logic        cfg_wr;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_term;
  logic        cfg_mode;
  logic [3:0]  out;
  logic [3:0]  done;
  logic [31:0] cnt_mon;

  int checks = 0;
  int errors = 0;

  pulse_gen_multi #(.CHANNELS(4), .WIDTH(32), .RST_TERM(21)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_term (cfg_term),
    .cfg_mode (cfg_mode),
    .out      (out),
    .done     (done),
    .cnt_mon  (cnt_mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  run;
    logic        clr;
    logic        wr;
    logic [1:0]  ch;
    logic [31:0] term;
    logic        mode;
    logic [3:0]  e_out;
    logic [3:0]  e_done;
    logic [31:0] e_mon;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    run      = '0;
    clr      = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_term = '0;
    cfg_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [31:0] term, input logic mode);
    cfg_wr   = 1'b1;
    cfg_ch   = ch;
    cfg_term = term;
    cfg_mode = mode;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // Edges until out[ch] is seen high; -1 if the bound expires.
  task automatic wait_pulse(input int ch, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      if (out[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt_hi;

    vecs[0]  = '{4'b0000, 1'b0, 1'b1, 2'd1, 32'd2, 1'b0, 4'b0000, 4'b0000, 32'd0};
    vecs[1]  = '{4'b0000, 1'b0, 1'b1, 2'd3, 32'd1, 1'b1, 4'b0000, 4'b0000, 32'd0};
    vecs[2]  = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b0000, 32'd0};
    vecs[3]  = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b1000, 4'b1000, 32'd1};
    vecs[4]  = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0010, 4'b1000, 32'd2};
    vecs[5]  = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd0};
    vecs[6]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd1};
    vecs[7]  = '{4'b0000, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd1};
    vecs[8]  = '{4'b0010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd1};
    vecs[9]  = '{4'b0010, 1'b0, 1'b1, 2'd1, 32'd5, 1'b0, 4'b0000, 4'b1000, 32'd2};
    vecs[10] = '{4'b0010, 1'b0, 1'b0, 2'd3, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd0};
    vecs[11] = '{4'b0010, 1'b1, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b0000, 32'd1};
    vecs[12] = '{4'b0010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b0000, 32'd0};
    vecs[13] = '{4'b0010, 1'b0, 1'b1, 2'd3, 32'd0, 1'b1, 4'b0000, 4'b0000, 32'd0};
    vecs[14] = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b1000, 4'b1000, 32'd2};
    vecs[15] = '{4'b1010, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 4'b0000, 4'b1000, 32'd3};

    // Reset values, then default term 21 -> pulse every 22 cycles.
    do_reset();
    check("rst_out", 32'(out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mon", cnt_mon, 32'd0);
    run = 4'b0001;
    wait_pulse(0, 60, n);
    check("default_first_pulse", n, 22);
    check("default_other_ch", 32'(out[3:1]), 32'd0);
    wait_pulse(0, 60, n);
    check("default_period", n, 22);
    tick();
    check("default_pulse_width", 32'(out[0]), 32'd0);

    // Table of short mixed-channel sequences.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run      = vecs[i].run;
      clr      = vecs[i].clr;
      cfg_wr   = vecs[i].wr;
      cfg_ch   = vecs[i].ch;
      cfg_term = vecs[i].term;
      cfg_mode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].e_out));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_mon", i), cnt_mon, vecs[i].e_mon);
    end
    clr = 1'b0; cfg_wr = 1'b0;

    // One-shot, term 4 on channel 2.
    do_reset();
    write_cfg(2'd2, 32'd4, 1'b1);
    run = 4'b0100;
    wait_pulse(2, 50, n);
    check("oneshot_latency", n, 5);
    check("oneshot_done_set", 32'(done[2]), 32'd1);
    cnt_hi = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (out[2]) cnt_hi++;
    end
    check("oneshot_no_repeat", cnt_hi, 0);
    check("oneshot_done_held", 32'(done[2]), 32'd1);

    // Pause channel 1 (term 9) at cnt 6 for three cycles.
    do_reset();
    write_cfg(2'd1, 32'd9, 1'b0);
    cfg_ch = 2'd1;
    run = 4'b0010;
    repeat (6) tick();
    run = 4'b0000;
    tick();
    check("pause_out_low", 32'(out[1]), 32'd0);
    tick();
    tick();
    check("pause_mon_hold", cnt_mon, 32'd6);
    run = 4'b0010;
    wait_pulse(1, 30, n);
    check("pause_late_pulse", (n < 0) ? -1 : 9 + n, 13);

    // Write on the exact terminal-hit cycle of channel 0.
    do_reset();
    write_cfg(2'd0, 32'd3, 1'b0);
    cfg_ch = 2'd0;
    run = 4'b0001;
    repeat (3) tick();
    write_cfg(2'd0, 32'd2, 1'b0);
    check("wr_beats_hit", 32'(out[0]), 32'd0);
    tick();
    check("wr_cnt_restart", cnt_mon, 32'd0);
    wait_pulse(0, 20, n);
    check("wr_new_term_period", n, 2);

    // clr while all four channels run.
    do_reset();
    write_cfg(2'd0, 32'd0, 1'b0);
    write_cfg(2'd1, 32'd3, 1'b0);
    write_cfg(2'd2, 32'd7, 1'b1);
    write_cfg(2'd3, 32'd1000, 1'b0);
    cfg_ch = 2'd3;
    run = 4'b1111;
    repeat (10) tick();
    check("pre_clr_done2", 32'(done), 32'b0100);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_out", 32'(out), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    tick();
    check("clr_cnt", cnt_mon, 32'd0);
    check("clr_t0_restart", 32'(out[0]), 32'd1);
    wait_pulse(1, 20, n);
    check("clr_cadence_ch1", n, 3);

    // term 0 periodic: continuous high; async reset mid-run.
    cnt_hi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out[0]) cnt_hi++;
    end
    check("t0_continuous", cnt_hi, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_mon", cnt_mon, 32'd0);
    tick();
    rst_n = 1'b1;
    run = 4'b0001;
    wait_pulse(0, 60, n);
    check("rst_term_restored", n, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
